// File: rtl/ack_bus_if.sv
// ACK bus requester interface.
// Groups the local completion handshake (done_*) and the arbiter/bus side
// (req, ack_ready, ack_valid, ack_tag) of one requester endpoint.
//   master : the requester endpoint (drives done_ready, req, ack_valid, ack_tag)
//   slave  : the surrounding logic / arbiter (drives done_valid, done_tag, ack_ready)
interface ack_bus_if #(
   parameter int TAG_W = 3
);
   logic             done_valid;
   logic [TAG_W-1:0] done_tag;
   logic             done_ready;
   logic             req;
   logic             ack_ready;
   logic             ack_valid;
   logic [TAG_W-1:0] ack_tag;

   modport master (
      input  done_valid, done_tag, ack_ready,
      output done_ready, req, ack_valid, ack_tag
   );

   modport slave (
      output done_valid, done_tag, ack_ready,
      input  done_ready, req, ack_valid, ack_tag
   );
endinterface

// File: rtl/ack_bus_requester.sv
// ACK bus requester endpoint.
// Queues local completion tags in a small FIFO and requests the shared ACK
// bus. When granted in SEND, the head tag is presented for one cycle, then
// req is dropped for one GAP cycle so lower-priority requesters can win.
// Ports:
//   clk, rst       system clock (rising edge), asynchronous active-high reset
//   bus            ack_bus_if.master: done_valid/done_tag/done_ready,
//                  req/ack_ready/ack_valid/ack_tag
//   pending_count  FIFO occupancy
//   overflow       sticky flag: a completion was dropped because the FIFO was full
//
// state | meaning
// IDLE  | nothing requested; leaves as soon as the FIFO holds an entry
// REQ   | req high, waiting for the arbiter grant
// SEND  | req high, head tag on the bus; beat taken only if still granted
// GAP   | req low for one cycle after a beat
module ack_bus_requester #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   ack_bus_if.master                    bus,
   output logic [$clog2(DEPTH+1)-1:0]   pending_count,
   output logic                         overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // req is state[0]: REQ and SEND are the only encodings with bit 0 set
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      SEND = 2'b11,
      GAP  = 2'b10
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [TAG_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   assign bus.done_ready = (count != CNT_W'(DEPTH));
   assign bus.req        = (state == REQ) || (state == SEND);
   // Preemption in SEND shows up as ack_ready low: no beat, head kept.
   assign bus.ack_valid  = (state == SEND) && bus.ack_ready;
   assign bus.ack_tag    = (count == '0) ? '0 : mem[rd_ptr];
   assign pending_count  = count;

   assign push = bus.done_valid && bus.done_ready;
   assign pop  = bus.ack_valid;

   // Tag storage carries no reset; ack_tag is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.done_tag;
      end
   end

   // Pointers are PTR_W bits wide, so DEPTH being a power of two gives the wrap for free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (bus.done_valid && !bus.done_ready) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (count != '0) state_nxt = REQ;
         REQ:     if (bus.ack_ready) state_nxt = SEND;
         SEND:    state_nxt = bus.ack_ready ? GAP : REQ;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ack_bus_requester.sv
// Testbench for ack_bus_requester: directed stimulus with a tag scoreboard.
// Stimulus pushes expected tags into exp_q; a negedge monitor pops and
// compares whenever ack_valid is seen, and checks the req=0 gap after each beat.
module tb_ack_bus_requester;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       grant_en = 1'b0;
   logic [2:0] pending_count;
   logic       overflow;
   logic [2:0] exp_q [$];
   int         n_checks = 0;
   int         n_pass = 0;

   ack_bus_if #(.TAG_W(3)) bus ();

   ack_bus_requester #(.DEPTH(4), .TAG_W(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .pending_count (pending_count),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   // Arbiter stand-in: grant follows req while grant_en is set.
   always_comb bus.ack_ready = grant_en & bus.req;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_send();
      int n = 0;
      while (!bus.ack_valid && n < 20) begin
         tick();
         n++;
      end
      check("send_reached", bus.ack_valid, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || pending_count != 0) && n < 64) begin
         tick();
         n++;
      end
      check("drain_count", pending_count, 0);
      check("drain_queue", exp_q.size(), 0);
      tick();
      tick();
   endtask

   // Monitor: scoreboard compare on each beat, then demand a req=0 gap cycle.
   initial begin
      logic gap_due;
      gap_due = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            gap_due = 1'b0;
         end else begin
            if (gap_due) begin
               check("gap_req", bus.req, 0);
               gap_due = 1'b0;
            end
            if (bus.ack_valid) begin
               if (exp_q.size() == 0) begin
                  check("beat_with_empty_queue", bus.ack_valid, 0);
               end else begin
                  check("beat_tag", bus.ack_tag, exp_q.pop_front());
               end
               gap_due = 1'b1;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.done_valid = 1'b0;
      bus.done_tag   = '0;

      // 1: reset with done_valid toggling
      for (int i = 0; i < 4; i++) begin
         bus.done_valid = i[0];
         bus.done_tag   = 3'(i + 1);
         tick();
      end
      check("rst_req", bus.req, 0);
      check("rst_ack_valid", bus.ack_valid, 0);
      check("rst_ack_tag", bus.ack_tag, 0);
      check("rst_count", pending_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_done_ready", bus.done_ready, 1);
      bus.done_valid = 1'b0;
      rst = 1'b0;
      tick();
      check("post_rst_count", pending_count, 0);
      check("post_rst_req", bus.req, 0);

      // 2: single ack, grant tied to req
      grant_en = 1'b1;
      bus.done_valid = 1'b1;
      bus.done_tag   = 3'h5;
      exp_q.push_back(3'h5);
      tick();
      bus.done_valid = 1'b0;
      check("t2_req_after_push", bus.req, 0);
      check("t2_count_1", pending_count, 1);
      check("t2_head_tag", bus.ack_tag, 5);
      tick();
      check("t2_req_high", bus.req, 1);
      check("t2_no_beat_in_req", bus.ack_valid, 0);
      tick();
      check("t2_beat_valid", bus.ack_valid, 1);
      check("t2_beat_tag", bus.ack_tag, 5);
      tick();
      check("t2_gap_req", bus.req, 0);
      check("t2_count_0", pending_count, 0);
      tick();
      check("t2_idle_req", bus.req, 0);
      check("t2_queue_empty", exp_q.size(), 0);

      // 3: preemption in SEND
      bus.done_valid = 1'b1;
      bus.done_tag   = 3'h2;
      exp_q.push_back(3'h2);
      tick();
      bus.done_valid = 1'b0;
      wait_send();
      grant_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_req_held", bus.req, 1);
         check("t3_no_pop", pending_count, 1);
         check("t3_tag_kept", bus.ack_tag, 2);
      end
      grant_en = 1'b1;
      drain();

      // 4: full and overflow with grant withheld
      grant_en = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         bus.done_valid = 1'b1;
         bus.done_tag   = 3'(i);
         if (i <= 4) exp_q.push_back(3'(i));
         tick();
      end
      bus.done_valid = 1'b0;
      check("t4_count_full", pending_count, 4);
      check("t4_done_ready", bus.done_ready, 0);
      check("t4_overflow", overflow, 1);
      check("t4_head", bus.ack_tag, 1);
      grant_en = 1'b1;
      drain();
      check("t4_overflow_sticky", overflow, 1);

      // 5: push during the pop cycle, enough rounds to wrap the pointers
      grant_en = 1'b0;
      bus.done_valid = 1'b1;
      bus.done_tag   = 3'h6;
      exp_q.push_back(3'h6);
      tick();
      bus.done_tag   = 3'h7;
      exp_q.push_back(3'h7);
      tick();
      bus.done_valid = 1'b0;
      check("t5_count_2", pending_count, 2);
      grant_en = 1'b1;
      for (int r = 0; r < 8; r++) begin
         wait_send();
         check("t5_pre_pop_count", pending_count, 2);
         bus.done_valid = 1'b1;
         bus.done_tag   = 3'(r * 3 + 1);
         exp_q.push_back(3'(r * 3 + 1));
         tick();
         bus.done_valid = 1'b0;
         check("t5_push_pop_count", pending_count, 2);
      end
      drain();

      // 6: asynchronous reset during SEND
      bus.done_valid = 1'b1;
      bus.done_tag   = 3'h4;
      exp_q.push_back(3'h4);
      tick();
      bus.done_tag   = 3'h1;
      exp_q.push_back(3'h1);
      tick();
      bus.done_valid = 1'b0;
      wait_send();
      #1;
      rst = 1'b1;
      #1;
      check("t6_req_async", bus.req, 0);
      check("t6_ack_valid_async", bus.ack_valid, 0);
      check("t6_count_async", pending_count, 0);
      exp_q.delete();
      tick();
      rst = 1'b0;
      tick();
      check("t6_count_after", pending_count, 0);
      check("t6_tag_after", bus.ack_tag, 0);
      check("t6_req_after", bus.req, 0);
      check("t6_overflow_cleared", overflow, 0);
      check("t6_done_ready", bus.done_ready, 1);
      tick();
      tick();
      check("t6_stays_idle", bus.req, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
